branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage counterpart of the decode-stage dual-issue branch predictor.
- Evaluates conditional branches in both issue slots and compares each outcome against the prediction carried down from D.
- Produces the registered update packet (branch, actual_take, PC) that trains the predictor.
- On a misprediction, raises flush and a redirect-PC request to fetch, held under a valid/ready handshake. Also keeps branch and misprediction counters.

Parameters:
- CNT_W, 32, width of the branch and misprediction counters.
- RESET_PC, 32'hBFC00000, redirect_pc value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stallE  in  1  E stage held; no resolution this cycle
- flushE  in  1  E contents squashed; no resolution this cycle
- valid1E, valid2E  in  1 each  slot holds a real instruction
- instr1E, instr2E  in  32 each  instruction words
- pc1E, pc2E  in  32 each  instruction PCs
- srca1E, srcb1E, srca2E, srcb2E  in  32 each  forwarded rs/rt operands
- pred_take1E, pred_take2E  in  1 each  predictor's D-stage decision, piped to E
- redirect_ready  in  1  fetch accepts redirect
- upd_branch1, upd_branch2  out  1 each  predictor update strobes
- upd_take1, upd_take2  out  1 each  actual direction
- upd_pc1, upd_pc2  out  32 each  PC of the resolved branch
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  correct next-fetch PC
- flush_younger  out  1  kill all instructions younger than the delay slot
- nullify_ds  out  1  annul the delay slot (branch-likely, not taken)
- branch_cnt, mispred_cnt  out  CNT_W each  statistics

Behaviour:
- Branch decode, per slot:
  - op[31:28] = 4'b0001: beq, bne, blez, bgtz.
  - op = 6'b000001 (REGIMM) with rt[19:17] in {000, 001}: bltz, bgez, bltzal, bgezal and the -l variants. Likely = rt[17].
  - Anything else is not a branch.
- Conditions, 32-bit signed:
  - beq: a==b; bne: a!=b.
  - blez: a<=0; bgtz: a>0.
  - bltz*: a[31]; bgez*: ~a[31].
- Target and redirect PC:
  - target = pc+4 + {signext(imm16), 2'b00}, wrap mod 2^32.
  - Fall-through = pc+8.
  - redirect_pc = actual ? target : pc+8.
- Resolve enable: resN = validN & isbranchN & ~stallE & ~flushE.
- Slot 2 is resolved only if slot 1 is not a branch. Slot 2 is then slot 1's delay slot, and a branch in a delay slot is ignored.
- Mispredict: misN = resN & (pred_takeN != actualN). Slot 1 has priority.
- All outputs are registered. Latency is 1 cycle from the E cycle.
- upd_* are single-cycle pulses, one per resolved branch, with no back-pressure.
- nullify_ds pulses with upd_branch1 when slot 1 is a likely branch and is not taken.
- FSM, two states:
  - IDLE: on mis1|mis2 -> PEND. Same edge: load redirect_pc, set redirect_valid=1 and flush_younger=1.
  - PEND: hold redirect_valid, redirect_pc and flush_younger stable. All new misN are ignored (wrong path); upd_* still fire.
  - PEND with redirect_ready=1 -> IDLE. Same edge: clear redirect_valid and flush_younger. A misN in that cycle is ignored.
  - IDLE with redirect_ready is don't-care.
- Counters:
  - branch_cnt += res1 + (slot-2 resolve).
  - mispred_cnt += 1 for each accepted mispredict, i.e. the IDLE->PEND transition.
  - Both wrap at 2^CNT_W.
- Reset: IDLE; all strobes 0; counters 0; redirect_pc = RESET_PC; upd_pc* = 0. Reset mid-PEND drops the request on the same edge.

Decomposition:
- Package branch_pkg holds:
  - opcode and REGIMM constants: OP_REGIMM=6'b000001, OP_BEQ_GRP=4'b0001;
  - FSM enum {IDLE, PEND};
  - the 2-bit counter encodings (SNT=00, WNT=01, WT=11, ST=10) shared with the predictor.
- Sub-module branch_eval, instantiated twice. Combinational: instr, pc, a, b -> isbranch, likely, actual, redirect_pc.

Test Plan:
- Correct prediction: beq at pc=0x80000100 with a=b=5, pred=1 -> next cycle upd_branch1=1, upd_take1=1, upd_pc1=0x80000100; redirect_valid=0; branch_cnt=1.
- Taken mispredict: bne at pc=0x80000200, imm=0x0010, a=1, b=2, pred=0 -> redirect_valid=1, redirect_pc=0x80000244, flush_younger=1, mispred_cnt=1; both held 3 cycles with ready=0, then cleared one cycle after ready=1.
- Not-taken mispredict in slot 2: slot 1 is an add, slot 2 is bgtz at 0x80000304 with a=0xFFFFFFFF, pred=1 -> redirect_pc=0x8000030C, upd_take2=0.
- Branch-likely: bgezl with a=0x80000000, pred=0 -> upd_take1=0, nullify_ds=1, no redirect.
- Masking:
  - stallE=1 with a branch present -> no upd pulse, counters unchanged.
  - Slot 1 beq plus slot 2 bne -> only upd_branch1.
  - Second mispredict during PEND -> mispred_cnt unchanged, redirect_pc unchanged.
- Reset during PEND -> next cycle redirect_valid=0, redirect_pc=0xBFC00000, counters 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and types for the branch predictor / resolve pair.
package branch_pkg;

    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [3:0] OP_BEQ_GRP = 4'b0001;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } brs_state_t;

    // 2-bit saturating counter encoding used by the D-stage predictor tables
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b11,
        ST  = 2'b10
    } bp_cnt_t;

endpackage

// File: rtl/branch_resolve_unit_eval.sv
// Combinational evaluation of one issue slot: branch decode, condition, next PC.
module branch_eval
    import branch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        isbranch,
    output logic        likely,
    output logic        actual,
    output logic [31:0] redirect_pc
);

    logic        is_beq_grp;
    logic        is_regimm;
    logic        cond;
    logic [31:0] target;
    logic        unused_fields;

    // Only rs/link bits are irrelevant to direction and target.
    assign unused_fields = ^instr[25:20];

    assign is_beq_grp = (instr[31:28] == OP_BEQ_GRP);
    // rt[3:2]==00 selects bltz/bgez and their -l/-al variants
    assign is_regimm  = (instr[31:26] == OP_REGIMM) && (instr[19:18] == 2'b00);
    assign isbranch   = is_beq_grp | is_regimm;
    assign likely     = is_regimm & instr[17];

    always_comb begin
        cond = 1'b0;
        if (is_beq_grp) begin
            case (instr[27:26])
                2'b00:   cond = (a == b);
                2'b01:   cond = (a != b);
                2'b10:   cond = ($signed(a) <= 32'sd0);
                default: cond = ($signed(a) > 32'sd0);
            endcase
        end else if (is_regimm) begin
            cond = instr[16] ? ~a[31] : a[31];
        end
    end

    assign actual      = isbranch & cond;
    assign target      = pc + 32'd4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign redirect_pc = actual ? target : (pc + 32'd8);

endmodule

// File: rtl/branch_resolve_unit.sv
// E-stage branch resolution: predictor training packet, redirect handshake, stats.
module branch_resolve_unit
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             valid1E,
    input  logic             valid2E,
    input  logic [31:0]      instr1E,
    input  logic [31:0]      instr2E,
    input  logic [31:0]      pc1E,
    input  logic [31:0]      pc2E,
    input  logic [31:0]      srca1E,
    input  logic [31:0]      srcb1E,
    input  logic [31:0]      srca2E,
    input  logic [31:0]      srcb2E,
    input  logic             pred_take1E,
    input  logic             pred_take2E,
    input  logic             redirect_ready,
    output logic             upd_branch1,
    output logic             upd_branch2,
    output logic             upd_take1,
    output logic             upd_take2,
    output logic [31:0]      upd_pc1,
    output logic [31:0]      upd_pc2,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_younger,
    output logic             nullify_ds,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    import branch_pkg::*;

    logic        isb1, isb2, lk1, lk2, act1, act2;
    logic [31:0] rpc1, rpc2;
    logic        res1, res2, mis1, mis2, accept;
    brs_state_t  state, state_nxt;

    branch_eval u_eval1 (
        .instr(instr1E), .pc(pc1E), .a(srca1E), .b(srcb1E),
        .isbranch(isb1), .likely(lk1), .actual(act1), .redirect_pc(rpc1)
    );

    branch_eval u_eval2 (
        .instr(instr2E), .pc(pc2E), .a(srca2E), .b(srcb2E),
        .isbranch(isb2), .likely(lk2), .actual(act2), .redirect_pc(rpc2)
    );

    always_comb begin
        res1      = valid1E & isb1 & ~stallE & ~flushE;
        // a branch sitting in slot 1's delay slot is not resolved
        res2      = valid2E & isb2 & ~(valid1E & isb1) & ~stallE & ~flushE;
        mis1      = res1 & (pred_take1E != act1);
        mis2      = res2 & (pred_take2E != act2);
        accept    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mis1 | mis2) begin
                    accept    = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (redirect_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign redirect_valid = (state == PEND);
    assign flush_younger  = (state == PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_branch1 <= 1'b0;
            upd_branch2 <= 1'b0;
            upd_take1   <= 1'b0;
            upd_take2   <= 1'b0;
            upd_pc1     <= 32'd0;
            upd_pc2     <= 32'd0;
            nullify_ds  <= 1'b0;
            redirect_pc <= RESET_PC;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            upd_branch1 <= res1;
            upd_branch2 <= res2;
            upd_take1   <= res1 & act1;
            upd_take2   <= res2 & act2;
            if (res1)
                upd_pc1 <= pc1E;
            if (res2)
                upd_pc2 <= pc2E;
            nullify_ds  <= res1 & lk1 & ~act1;
            branch_cnt  <= branch_cnt + CNT_W'(res1) + CNT_W'(res2);
            if (accept) begin
                redirect_pc <= mis1 ? rpc1 : rpc2;
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, stallE, flushE, valid1E, valid2E;
    logic [31:0] instr1E, instr2E, pc1E, pc2E, srca1E, srcb1E, srca2E, srcb2E;
    logic        pred_take1E, pred_take2E, redirect_ready;
    logic        upd_branch1, upd_branch2, upd_take1, upd_take2;
    logic [31:0] upd_pc1, upd_pc2, redirect_pc;
    logic        redirect_valid, flush_younger, nullify_ds;
    logic [31:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_pend;
    logic [31:0] m_rpc, m_bcnt, m_mcnt, m_upc1, m_upc2;
    logic        m_ub1, m_ub2, m_ut1, m_ut2, m_nul;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
        .valid1E(valid1E), .valid2E(valid2E), .instr1E(instr1E), .instr2E(instr2E),
        .pc1E(pc1E), .pc2E(pc2E), .srca1E(srca1E), .srcb1E(srcb1E),
        .srca2E(srca2E), .srcb2E(srcb2E), .pred_take1E(pred_take1E),
        .pred_take2E(pred_take2E), .redirect_ready(redirect_ready),
        .upd_branch1(upd_branch1), .upd_branch2(upd_branch2),
        .upd_take1(upd_take1), .upd_take2(upd_take2),
        .upd_pc1(upd_pc1), .upd_pc2(upd_pc2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_younger(flush_younger), .nullify_ds(nullify_ds),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Mnemonic-level reference: classify by opcode / rt field, then apply the rule.
    task automatic ref_eval(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic isb, output logic lk, output logic act,
                            output logic [31:0] npc);
        int sa;
        sa  = $signed(a);
        isb = 1'b1;
        lk  = 1'b0;
        act = 1'b0;
        case (ins[31:26])
            6'h04: act = (a == b);
            6'h05: act = (a != b);
            6'h06: act = (sa <= 0);
            6'h07: act = (sa > 0);
            6'h01: begin
                case (ins[20:16])
                    5'h00, 5'h10: act = (sa < 0);
                    5'h01, 5'h11: act = (sa >= 0);
                    5'h02, 5'h12: begin act = (sa < 0);  lk = 1'b1; end
                    5'h03, 5'h13: begin act = (sa >= 0); lk = 1'b1; end
                    default: isb = 1'b0;
                endcase
            end
            default: isb = 1'b0;
        endcase
        if (act)
            npc = pc + 4 + 32'($signed(ins[15:0]) * 4);
        else
            npc = pc + 8;
    endtask

    task automatic model_edge();
        logic isb1, lk1, act1, isb2, lk2, act2, r1, r2, mi1, mi2;
        logic [31:0] n1, n2;
        ref_eval(instr1E, pc1E, srca1E, srcb1E, isb1, lk1, act1, n1);
        ref_eval(instr2E, pc2E, srca2E, srcb2E, isb2, lk2, act2, n2);
        r1  = valid1E && isb1 && !stallE && !flushE;
        r2  = valid2E && isb2 && !(valid1E && isb1) && !stallE && !flushE;
        mi1 = r1 && (pred_take1E != act1);
        mi2 = r2 && (pred_take2E != act2);
        if (rst) begin
            m_pend = 0; m_rpc = 32'hBFC00000; m_bcnt = 0; m_mcnt = 0;
            m_ub1 = 0; m_ub2 = 0; m_ut1 = 0; m_ut2 = 0; m_nul = 0;
            m_upc1 = 0; m_upc2 = 0;
        end else begin
            m_ub1 = r1; m_ub2 = r2;
            m_ut1 = act1; m_ut2 = act2;
            if (r1) m_upc1 = pc1E;
            if (r2) m_upc2 = pc2E;
            m_nul  = r1 && lk1 && !act1;
            m_bcnt = m_bcnt + r1 + r2;
            if (!m_pend) begin
                if (mi1 || mi2) begin
                    m_pend = 1;
                    m_rpc  = mi1 ? n1 : n2;
                    m_mcnt = m_mcnt + 1;
                end
            end else if (redirect_ready) begin
                m_pend = 0;
            end
        end
    endtask

    task automatic check_all();
        check("upd_branch1", 32'(upd_branch1), 32'(m_ub1));
        check("upd_branch2", 32'(upd_branch2), 32'(m_ub2));
        if (m_ub1) begin
            check("upd_take1", 32'(upd_take1), 32'(m_ut1));
            check("upd_pc1", upd_pc1, m_upc1);
        end
        if (m_ub2) begin
            check("upd_take2", 32'(upd_take2), 32'(m_ut2));
            check("upd_pc2", upd_pc2, m_upc2);
        end
        check("nullify_ds", 32'(nullify_ds), 32'(m_nul));
        check("redirect_valid", 32'(redirect_valid), 32'(m_pend));
        check("flush_younger", 32'(flush_younger), 32'(m_pend));
        check("redirect_pc", redirect_pc, m_rpc);
        check("branch_cnt", branch_cnt, m_bcnt);
        check("mispred_cnt", mispred_cnt, m_mcnt);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        stallE = 0; flushE = 0; valid1E = 1; valid2E = 1;
        instr1E = 32'h0000_0020; instr2E = 32'h0000_0020;
        pc1E = 32'h8000_0000; pc2E = 32'h8000_0004;
        srca1E = 0; srcb1E = 0; srca2E = 0; srcb2E = 0;
        pred_take1E = 0; pred_take2E = 0; redirect_ready = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0]  rts [8];
        rts = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h10, 5'h11, 5'h12, 5'h13};
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'h04;
            1: w[31:26] = 6'h05;
            2: w[31:26] = 6'h06;
            3: w[31:26] = 6'h07;
            4, 5: begin w[31:26] = 6'h01; w[20:16] = rts[$urandom_range(0, 7)]; end
            6: begin w[31:26] = 6'h01; w[20:16] = 5'h04 | 5'($urandom_range(0, 3)); end
            default: w[31:26] = 6'h14 | 6'($urandom_range(0, 3));
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] saved_b, saved_m, saved_r;
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        check("reset_redirect_pc", redirect_pc, 32'hBFC00000);
        check("reset_branch_cnt", branch_cnt, 32'd0);

        // correct prediction, beq taken
        instr1E = {6'h04, 5'd1, 5'd2, 16'h0008}; pc1E = 32'h8000_0100; pc2E = 32'h8000_0104;
        srca1E = 5; srcb1E = 5; pred_take1E = 1;
        step();
        check("beq_upd_pc1", upd_pc1, 32'h8000_0100);
        check("beq_take1", 32'(upd_take1), 32'd1);
        check("beq_branch_cnt", branch_cnt, 32'd1);
        idle_inputs();

        // taken mispredict, held with ready low
        instr1E = {6'h05, 5'd1, 5'd2, 16'h0010}; pc1E = 32'h8000_0200; pc2E = 32'h8000_0204;
        srca1E = 1; srcb1E = 2; pred_take1E = 0;
        step();
        check("bne_redirect_pc", redirect_pc, 32'h8000_0244);
        check("bne_mispred_cnt", mispred_cnt, 32'd1);
        idle_inputs();
        step();
        step();
        check("bne_held_valid", 32'(redirect_valid), 32'd1);
        redirect_ready = 1;
        step();
        check("bne_cleared", 32'(redirect_valid), 32'd0);
        idle_inputs();

        // not-taken mispredict in slot 2
        pc1E = 32'h8000_0300; instr2E = {6'h07, 5'd3, 5'd0, 16'h0040}; pc2E = 32'h8000_0304;
        srca2E = 32'hFFFF_FFFF; pred_take2E = 1;
        step();
        check("bgtz_redirect_pc", redirect_pc, 32'h8000_030C);
        check("bgtz_take2", 32'(upd_take2), 32'd0);
        idle_inputs();
        redirect_ready = 1;
        step();
        idle_inputs();

        // branch-likely not taken
        instr1E = {6'h01, 5'd4, 5'h03, 16'h0020}; srca1E = 32'h8000_0000; pred_take1E = 0;
        step();
        check("bgezl_nullify", 32'(nullify_ds), 32'd1);
        check("bgezl_no_redirect", 32'(redirect_valid), 32'd0);
        idle_inputs();

        // stall masks resolution
        saved_b = branch_cnt;
        instr1E = {6'h04, 5'd1, 5'd2, 16'h0008}; stallE = 1; pred_take1E = 0;
        step();
        check("stall_branch_cnt", branch_cnt, saved_b);
        idle_inputs();

        // branch in delay slot ignored
        instr1E = {6'h04, 5'd1, 5'd2, 16'h0008}; instr2E = {6'h05, 5'd1, 5'd2, 16'h0008};
        srca1E = 3; srcb1E = 3; pred_take1E = 1;
        step();
        check("ds_branch2", 32'(upd_branch2), 32'd0);
        idle_inputs();

        // second mispredict during PEND, then reset mid-PEND
        instr1E = {6'h04, 5'd1, 5'd2, 16'h0100}; srca1E = 1; srcb1E = 1; pred_take1E = 0;
        step();
        saved_m = mispred_cnt; saved_r = redirect_pc;
        instr1E = {6'h05, 5'd1, 5'd2, 16'h0200}; srca1E = 1; srcb1E = 9; pred_take1E = 0;
        step();
        check("pend_mispred_cnt", mispred_cnt, saved_m);
        check("pend_redirect_pc", redirect_pc, saved_r);
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        check("rst_pend_valid", 32'(redirect_valid), 32'd0);
        check("rst_pend_pc", redirect_pc, 32'hBFC00000);
        check("rst_pend_mcnt", mispred_cnt, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            stallE         = ($urandom_range(0, 9) == 0);
            flushE         = ($urandom_range(0, 9) == 0);
            valid1E        = ($urandom_range(0, 7) != 0);
            valid2E        = ($urandom_range(0, 7) != 0);
            instr1E        = rand_instr();
            instr2E        = rand_instr();
            pc1E           = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            pc2E           = pc1E + 4;
            srca1E         = rand_opnd();
            srca2E         = rand_opnd();
            srcb1E         = $urandom_range(0, 1) ? srca1E : rand_opnd();
            srcb2E         = $urandom_range(0, 1) ? srca2E : rand_opnd();
            pred_take1E    = 1'($urandom);
            pred_take2E    = 1'($urandom);
            redirect_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
